// File: rtl/alu_flag_pipe.sv
// Result/flag buffer behind the 16-bit ALU: FIFO of {Z, flags} with a valid/ready
// handshake, plus sticky flag history, a saturating push counter and a ZR consistency check.
module alu_flag_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         z_in,
  input  logic [4:0]               flags_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         z_out,
  output logic [4:0]               flags_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic [4:0]               sticky,
  output logic [CNT_W-1:0]         op_count,
  output logic                     zr_err,
  input  logic                     stat_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = WIDTH + 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PW-1:0]      wrPtr_q, wrPtr_d;
  logic [PW-1:0]      rdPtr_q, rdPtr_d;
  logic [EW-1:0]      mem_q [DEPTH];
  logic [4:0]         sticky_q, sticky_d;
  logic [CNT_W-1:0]   opCount_q, opCount_d;
  logic               zrErr_q, zrErr_d;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               zrMismatch;
  logic [EW-1:0]      headEntry;

  // The extra wrap bit distinguishes full from empty when the index bits match.
  assign full       = (wrPtr_q[PW-1] != rdPtr_q[PW-1]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign empty      = (wrPtr_q == rdPtr_q);
  assign in_ready   = !full;
  assign out_valid  = !empty;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign level      = wrPtr_q - rdPtr_q;
  assign zrMismatch = flags_in[3] != (z_in == '0);

  assign headEntry  = mem_q[rdPtr_q[AW-1:0]];
  assign z_out      = empty ? '0 : headEntry[EW-1:5];
  assign flags_out  = empty ? '0 : headEntry[4:0];

  assign sticky     = sticky_q;
  assign op_count   = opCount_q;
  assign zr_err     = zrErr_q;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (push) wrPtr_d = wrPtr_q + PW'(1);
    if (pop)  rdPtr_d = rdPtr_q + PW'(1);
  end

  // A clear in the same cycle as a push wipes old history before the push lands.
  always_comb begin
    sticky_d  = stat_clr ? '0 : sticky_q;
    opCount_d = stat_clr ? '0 : opCount_q;
    zrErr_d   = stat_clr ? 1'b0 : zrErr_q;
    if (push) begin
      sticky_d = sticky_d | flags_in;
      if (opCount_d != CNT_MAX) opCount_d = opCount_d + CNT_W'(1);
      zrErr_d = zrErr_d | zrMismatch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      sticky_q  <= '0;
      opCount_q <= '0;
      zrErr_q   <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      sticky_q  <= sticky_d;
      opCount_q <= opCount_d;
      zrErr_q   <= zrErr_d;
    end
  end

  // Storage is left unreset; outputs are gated to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q[AW-1:0]] <= {z_in, flags_in};
  end

endmodule

// File: tb/tb_alu_flag_pipe.sv
// Directed self-checking bench for alu_flag_pipe (WIDTH=16, DEPTH=4, CNT_W=8).
module tb_alu_flag_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] z_in;
  logic [4:0]  flags_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] z_out;
  logic [4:0]  flags_out;
  logic [2:0]  level;
  logic [4:0]  sticky;
  logic [7:0]  op_count;
  logic        zr_err;
  logic        stat_clr;

  int checkCount = 0;
  int failCount  = 0;

  alu_flag_pipe #(.WIDTH(16), .DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z_in      (z_in),
    .flags_in  (flags_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z_out     (z_out),
    .flags_out (flags_out),
    .level     (level),
    .sticky    (sticky),
    .op_count  (op_count),
    .zr_err    (zr_err),
    .stat_clr  (stat_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] z, input logic [4:0] f,
                               input logic rdy, input logic clr);
    in_valid  = v;
    z_in      = z;
    flags_in  = f;
    out_ready = rdy;
    stat_clr  = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0000, 5'b00000, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;

    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_z_out", z_out, 16'h0000);
    checkOutput("rst_flags_out", flags_out, 0);
    checkOutput("rst_sticky", sticky, 0);
    checkOutput("rst_op_count", op_count, 0);
    checkOutput("rst_zr_err", zr_err, 0);

    // single push: 8fff+8000 -> 0fff with CY,V
    applyStimulus(1'b1, 16'h0fff, 5'b00101, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 5'b00000, 1'b0, 1'b0);
    checkOutput("one_out_valid", out_valid, 1);
    checkOutput("one_z_out", z_out, 16'h0fff);
    checkOutput("one_flags_out", flags_out, 5'b00101);
    checkOutput("one_sticky", sticky, 5'b00101);
    checkOutput("one_op_count", op_count, 1);
    checkOutput("one_zr_err", zr_err, 0);
    checkOutput("one_level", level, 1);

    applyStimulus(1'b0, 16'h0000, 5'b00000, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 5'b00000, 1'b0, 1'b0);
    checkOutput("drain1_level", level, 0);
    checkOutput("clr_sticky", sticky, 0);
    checkOutput("clr_op_count", op_count, 0);

    // two pushes held, then popped in order
    applyStimulus(1'b1, 16'h0000, 5'b01100, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'hffff, 5'b10000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 5'b00000, 1'b0, 1'b0);
    checkOutput("two_level", level, 2);
    checkOutput("two_sticky", sticky, 5'b11100);
    checkOutput("two_op_count", op_count, 2);
    checkOutput("two_zr_err", zr_err, 0);
    checkOutput("two_head0_z", z_out, 16'h0000);
    checkOutput("two_head0_f", flags_out, 5'b01100);
    out_ready = 1'b1;
    tick();
    checkOutput("two_head1_z", z_out, 16'hffff);
    checkOutput("two_head1_f", flags_out, 5'b10000);
    tick();
    out_ready = 1'b0;
    checkOutput("two_empty_valid", out_valid, 0);
    checkOutput("two_empty_z", z_out, 16'h0000);

    // fill to DEPTH
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'h00a1 + 16'(i), 5'b00000, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 16'h0000, 5'b00000, 1'b0, 1'b0);
    checkOutput("full_in_ready", in_ready, 0);
    checkOutput("full_level", level, 4);
    checkOutput("full_op_count", op_count, 6);
    applyStimulus(1'b1, 16'h1234, 5'b01000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 5'b00000, 1'b0, 1'b0);
    checkOutput("full_drop_level", level, 4);
    checkOutput("full_drop_op_count", op_count, 6);
    checkOutput("full_drop_zr_err", zr_err, 0);
    checkOutput("full_drop_sticky", sticky, 5'b11100);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("full_pop_z", z_out, 16'h00a1 + 32'(i));
      tick();
      if (i == 0) checkOutput("full_pop_ready", in_ready, 1);
    end
    out_ready = 1'b0;
    checkOutput("full_after_level", level, 0);
    checkOutput("full_after_valid", out_valid, 0);

    // streaming at level 2
    applyStimulus(1'b1, 16'h0001, 5'b00000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h0002, 5'b00000, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 16'h0003 + 16'(i), 5'b00000, 1'b1, 1'b0);
      checkOutput("stream_z", z_out, 32'h1 + 32'(i));
      tick();
      checkOutput("stream_level", level, 2);
    end
    applyStimulus(1'b0, 16'h0000, 5'b00000, 1'b1, 1'b0);
    checkOutput("stream_op_count", op_count, 18);
    checkOutput("stream_tail0", z_out, 16'h000b);
    tick();
    checkOutput("stream_tail1", z_out, 16'h000c);
    tick();
    checkOutput("stream_empty", out_valid, 0);

    // ZR consistency, then clear with concurrent push
    applyStimulus(1'b1, 16'h0005, 5'b01000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 5'b00000, 1'b0, 1'b0);
    checkOutput("zr_err_set", zr_err, 1);
    checkOutput("zr_op_count", op_count, 19);
    applyStimulus(1'b1, 16'h0000, 5'b01000, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 5'b00000, 1'b0, 1'b0);
    checkOutput("clrpush_sticky", sticky, 5'b01000);
    checkOutput("clrpush_op_count", op_count, 1);
    checkOutput("clrpush_zr_err", zr_err, 0);
    checkOutput("clrpush_level", level, 2);
    checkOutput("clrpush_head", z_out, 16'h0005);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    checkOutput("clrpush_drained", level, 0);

    // saturation: 300 more pushes on top of op_count=1
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 16'(i + 1), 5'b00000, 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 16'h0000, 5'b00000, 1'b1, 1'b0);
    checkOutput("sat_op_count", op_count, 255);
    checkOutput("sat_level", level, 1);
    checkOutput("sat_last_z", z_out, 16'd300);
    tick();
    out_ready = 1'b0;

    // asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'h0c00 + 16'(i), 5'b00000, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 16'h0000, 5'b00000, 1'b0, 1'b0);
    checkOutput("pre_rst_level", level, 3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_level", level, 0);
    checkOutput("async_rst_valid", out_valid, 0);
    checkOutput("async_rst_ready", in_ready, 1);
    checkOutput("async_rst_z", z_out, 16'h0000);
    checkOutput("async_rst_op_count", op_count, 0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("post_rst_level", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
